// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ceiling log2, floored at 1 so WIDTH=2 still gets a 1-bit counter.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell; purely combinational, zero latency, no flow control.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/sub, LSB first through one fulladder; done pulses WIDTH edges after start.
// start is only honoured in IDLE (no queuing). Overflow flag built only with SERIAL_ADDSUB_OVF_EN.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_cout;
  logic             last_bit;

  fulladder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B here and seed the carry with 1.
          state_d = SHIFT;
          a_sr_d  = a;
          b_sr_d  = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d = fa_cout;
        if (last_bit) begin
          state_d = DONE;
          cout_d  = fa_cout;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;

  // On the MSB step carry_q is the carry into the MSB.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == SHIFT && last_bit) ovf_d = carry_q ^ fa_cout;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed vectors, handshake corner cases, random ops.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int checks;
  int failures;

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' unsigned and signed values.
  task automatic ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           output logic [W-1:0] r, output logic co, output logic ov);
    int ux, uy, sx, sy, sr;
    ux = int'(x);
    uy = int'(y);
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      r  = W'(ux - uy);
      co = (ux >= uy);
      sr = sx - sy;
    end else begin
      r  = W'(ux + uy);
      co = ((ux + uy) >= (1 << W));
      sr = sx + sy;
    end
    ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts,
                        input logic [W-1:0] er, input logic eco, input logic eov, input string tag);
    int n;
    logic ov_exp;
`ifdef SERIAL_ADDSUB_OVF_EN
    ov_exp = eov;
`else
    ov_exp = 1'b0 & eov;
`endif
    @(negedge clk);
    a = ta; b = tb_b; sub = ts; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    // Scramble operands: the DUT must be working from its captured copy.
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, W);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_cout"}, 32'(cout), 32'(eco));
    check({tag, "_ovf"}, 32'(overflow), 32'(ov_exp));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    logic [W-1:0] r;
    logic         co, ov;
    logic [W-1:0] ra, rb;
    logic         rs;
    int           dones;
    int           done_at[$];

    checks = 0;
    failures = 0;
    rst = 1'b1; start = 1'b1; sub = 1'b1; a = 8'hA5; b = 8'h5A;

    // Reset with start also high: reset must win.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);

    // Directed vectors with hand-derived results.
    run_op(8'd100, 8'd55, 1'b0, 8'h9B, 1'b0, 1'b1, "add_100_55");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_op(8'd5, 8'd3, 1'b1, 8'h02, 1'b1, 1'b0, "sub_5_3");
    run_op(8'd3, 8'd5, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_3_5");
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    run_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "sub_0_0");

    // start pulses at cycles 2 and 9 of a running operation are ignored.
    @(negedge clk);
    a = 8'd20; b = 8'd22; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'hEE; b = 8'hEE; sub = 1'b1;
    dones = 0;
    for (int k = 1; k <= 14; k++) begin
      start = (k == 2 || k == 9);
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    check("ignore_start_dones", dones, 1);
    check("ignore_start_idle", 32'(busy), 32'd0);
    check("ignore_start_result", 32'(result), 32'd42);

    // start held high retriggers every W+2 cycles.
    @(negedge clk);
    a = 8'd9; b = 8'd4; sub = 1'b1; start = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (done) done_at.push_back(k);
    end
    start = 1'b0;
    check("held_count", done_at.size(), 3);
    if (done_at.size() == 3) begin
      check("held_first", done_at[0], W);
      check("held_period1", done_at[1] - done_at[0], W + 2);
      check("held_period2", done_at[2] - done_at[1], W + 2);
    end
    repeat (12) @(negedge clk);
    check("held_result", 32'(result), 32'd5);

    // Reset during SHIFT discards the operation.
    @(negedge clk);
    a = 8'd200; b = 8'd100; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    ref_model(8'd77, 8'd200, 1'b1, r, co, ov);
    run_op(8'd77, 8'd200, 1'b1, r, co, ov, "after_rst");

    // Random operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      ref_model(ra, rb, rs, r, co, ov);
      run_op(ra, rb, rs, r, co, ov, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
